// File: rtl/commit_stage.sv
// In-order retirement at the ROB head: regfile write port, maptable clear,
// store commit handshake, mispredict flush and sticky halt/illegal stop.
module commit_stage #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4,
    parameter int CNT_W = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             head_valid,
    input  logic             head_ready,
    input  logic [TAG_W-1:0] head_tag,
    input  logic [4:0]       head_dest_reg_idx,
    input  logic [XLEN-1:0]  head_value,
    input  logic             head_wr_mem,
    input  logic [2:0]       head_mem_size,
    input  logic [XLEN-1:0]  head_addr,
    input  logic [XLEN-1:0]  head_store_value,
    input  logic             head_mispredict,
    input  logic [XLEN-1:0]  head_target_pc,
    input  logic             head_halt,
    input  logic             head_illegal,
    input  logic             mem_st_ack,
    output logic             rob_retire,
    output logic             map_clear_en,
    output logic [4:0]       map_clear_idx,
    output logic [TAG_W-1:0] map_clear_tag,
    output logic             wb_reg_wr_en_out,
    output logic [4:0]       wb_reg_wr_idx_out,
    output logic [XLEN-1:0]  wb_reg_wr_data_out,
    output logic             mem_st_req,
    output logic [XLEN-1:0]  mem_st_addr,
    output logic [XLEN-1:0]  mem_st_data,
    output logic [2:0]       mem_st_size,
    output logic             flush_out,
    output logic [XLEN-1:0]  flush_pc,
    output logic             halted,
    output logic             illegal_out,
    output logic [CNT_W-1:0] retired_count
);

    localparam logic [1:0] S_RUN     = 2'd0;
    localparam logic [1:0] S_ST_WAIT = 2'd1;
    localparam logic [1:0] S_FLUSH   = 2'd2;
    localparam logic [1:0] S_HALTED  = 2'd3;

    logic [1:0] state;
    logic       ret;
    logic       is_stop;
    logic       has_dest;

    assign ret      = head_valid & head_ready & (state == S_RUN);
    assign is_stop  = head_illegal | head_halt;
    assign has_dest = |head_dest_reg_idx;

    // Stops outrank stores, stores outrank mispredicts; a store pops only on ack.
    always_comb begin
        rob_retire    = 1'b0;
        map_clear_en  = 1'b0;
        map_clear_idx = '0;
        map_clear_tag = '0;
        if (ret && is_stop) begin
            rob_retire = 1'b1;
        end else if (ret && !head_wr_mem) begin
            rob_retire = 1'b1;
            if (has_dest) begin
                map_clear_en  = 1'b1;
                map_clear_idx = head_dest_reg_idx;
                map_clear_tag = head_tag;
            end
        end else if (state == S_ST_WAIT && mem_st_ack) begin
            rob_retire = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state              <= S_RUN;
            wb_reg_wr_en_out   <= 1'b0;
            wb_reg_wr_idx_out  <= '0;
            wb_reg_wr_data_out <= '0;
            mem_st_req         <= 1'b0;
            mem_st_addr        <= '0;
            mem_st_data        <= '0;
            mem_st_size        <= '0;
            flush_out          <= 1'b0;
            flush_pc           <= '0;
            halted             <= 1'b0;
            illegal_out        <= 1'b0;
            retired_count      <= '0;
        end else begin
            wb_reg_wr_en_out <= 1'b0;
            flush_out        <= 1'b0;
            if (rob_retire) begin
                retired_count <= retired_count + CNT_W'(1);
            end
            case (state)
                S_RUN: begin
                    if (ret) begin
                        if (is_stop) begin
                            halted      <= 1'b1;
                            illegal_out <= head_illegal;
                            state       <= S_HALTED;
                        end else if (head_wr_mem) begin
                            mem_st_req  <= 1'b1;
                            mem_st_addr <= head_addr;
                            mem_st_data <= head_store_value;
                            mem_st_size <= head_mem_size;
                            state       <= S_ST_WAIT;
                        end else begin
                            wb_reg_wr_en_out   <= has_dest;
                            wb_reg_wr_idx_out  <= head_dest_reg_idx;
                            wb_reg_wr_data_out <= head_value;
                            if (head_mispredict) begin
                                flush_out <= 1'b1;
                                flush_pc  <= head_target_pc;
                                state     <= S_FLUSH;
                            end
                        end
                    end
                end
                S_ST_WAIT: begin
                    if (mem_st_ack) begin
                        mem_st_req <= 1'b0;
                        state      <= S_RUN;
                    end
                end
                S_FLUSH:  state <= S_RUN;
                default:  state <= S_HALTED;
            endcase
        end
    end

endmodule

// File: tb/tb_commit_stage.sv
// Scoreboard bench for commit_stage: expected writebacks, stores and flushes are
// queued when the head is driven and popped when the DUT emits them.
module tb_commit_stage;
    localparam int XLEN  = 32;
    localparam int TAG_W = 4;
    localparam int CNT_W = 64;

    logic             clock = 1'b0;
    logic             reset;
    logic             head_valid, head_ready;
    logic [TAG_W-1:0] head_tag;
    logic [4:0]       head_dest_reg_idx;
    logic [XLEN-1:0]  head_value;
    logic             head_wr_mem;
    logic [2:0]       head_mem_size;
    logic [XLEN-1:0]  head_addr, head_store_value;
    logic             head_mispredict;
    logic [XLEN-1:0]  head_target_pc;
    logic             head_halt, head_illegal, mem_st_ack;
    logic             rob_retire, map_clear_en;
    logic [4:0]       map_clear_idx;
    logic [TAG_W-1:0] map_clear_tag;
    logic             wb_reg_wr_en_out;
    logic [4:0]       wb_reg_wr_idx_out;
    logic [XLEN-1:0]  wb_reg_wr_data_out;
    logic             mem_st_req;
    logic [XLEN-1:0]  mem_st_addr, mem_st_data;
    logic [2:0]       mem_st_size;
    logic             flush_out;
    logic [XLEN-1:0]  flush_pc;
    logic             halted, illegal_out;
    logic [CNT_W-1:0] retired_count;

    commit_stage #(.XLEN(XLEN), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset),
        .head_valid(head_valid), .head_ready(head_ready), .head_tag(head_tag),
        .head_dest_reg_idx(head_dest_reg_idx), .head_value(head_value),
        .head_wr_mem(head_wr_mem), .head_mem_size(head_mem_size),
        .head_addr(head_addr), .head_store_value(head_store_value),
        .head_mispredict(head_mispredict), .head_target_pc(head_target_pc),
        .head_halt(head_halt), .head_illegal(head_illegal), .mem_st_ack(mem_st_ack),
        .rob_retire(rob_retire), .map_clear_en(map_clear_en),
        .map_clear_idx(map_clear_idx), .map_clear_tag(map_clear_tag),
        .wb_reg_wr_en_out(wb_reg_wr_en_out), .wb_reg_wr_idx_out(wb_reg_wr_idx_out),
        .wb_reg_wr_data_out(wb_reg_wr_data_out),
        .mem_st_req(mem_st_req), .mem_st_addr(mem_st_addr), .mem_st_data(mem_st_data),
        .mem_st_size(mem_st_size), .flush_out(flush_out), .flush_pc(flush_pc),
        .halted(halted), .illegal_out(illegal_out), .retired_count(retired_count)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    int exp_count = 0;
    int exp_wb = 0;
    int wb_seen = 0;

    logic [36:0] wb_q[$];
    logic [66:0] st_q[$];
    logic [31:0] fl_q[$];
    logic [36:0] wb_e;
    logic [66:0] st_e;
    logic [31:0] fl_e;
    logic        prev_req = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Output-side scoreboard: every wb pulse, store request and flush must match the queue head.
    always @(negedge clock) begin
        if (wb_reg_wr_en_out) begin
            wb_seen++;
            if (wb_q.size() == 0) chk("wb_unexpected", 1, 0);
            else begin
                wb_e = wb_q.pop_front();
                chk("wb_idx", wb_reg_wr_idx_out, wb_e[36:32]);
                chk("wb_data", wb_reg_wr_data_out, wb_e[31:0]);
            end
        end
        if (mem_st_req && !prev_req) begin
            if (st_q.size() == 0) chk("st_unexpected", 1, 0);
            else begin
                st_e = st_q.pop_front();
                chk("st_addr", mem_st_addr, st_e[66:35]);
                chk("st_data", mem_st_data, st_e[34:3]);
                chk("st_size", mem_st_size, st_e[2:0]);
            end
        end
        if (flush_out) begin
            if (fl_q.size() == 0) chk("flush_unexpected", 1, 0);
            else begin
                fl_e = fl_q.pop_front();
                chk("flush_pc", flush_pc, fl_e);
            end
        end
        prev_req <= mem_st_req;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        head_valid = 0; head_ready = 0; head_tag = '0; head_dest_reg_idx = '0;
        head_value = '0; head_wr_mem = 0; head_mem_size = '0; head_addr = '0;
        head_store_value = '0; head_mispredict = 0; head_target_pc = '0;
        head_halt = 0; head_illegal = 0; mem_st_ack = 0;
    endtask

    task automatic set_head(input logic [3:0] tag, input logic [4:0] rd, input logic [31:0] val);
        idle();
        head_valid = 1; head_ready = 1; head_tag = tag;
        head_dest_reg_idx = rd; head_value = val;
    endtask

    task automatic alu(input logic [3:0] tag, input logic [4:0] rd, input logic [31:0] val,
                       input string nm);
        set_head(tag, rd, val);
        if (rd != 0) begin
            wb_q.push_back({rd, val});
            exp_wb++;
        end
        @(negedge clock);
        chk({nm, "_retire"}, rob_retire, 1);
        chk({nm, "_mclr_en"}, map_clear_en, rd != 0);
        if (rd != 0) begin
            chk({nm, "_mclr_idx"}, map_clear_idx, rd);
            chk({nm, "_mclr_tag"}, map_clear_tag, tag);
        end
        exp_count++;
        tick();
    endtask

    task automatic store_head(input logic [31:0] a, input logic [31:0] d, input logic [2:0] sz);
        set_head(4'd10, 5'd0, 32'd0);
        head_wr_mem = 1; head_addr = a; head_store_value = d; head_mem_size = sz;
        st_q.push_back({a, d, sz});
    endtask

    initial begin
        idle();
        reset = 1;
        tick(); tick();
        @(negedge clock);
        chk("rst_retire", rob_retire, 0);
        chk("rst_mclr", map_clear_en, 0);
        chk("rst_wb", wb_reg_wr_en_out, 0);
        chk("rst_req", mem_st_req, 0);
        chk("rst_flush", flush_out, 0);
        chk("rst_halted", halted, 0);
        chk("rst_illegal", illegal_out, 0);
        chk("rst_count", retired_count, 0);
        reset = 0;
        tick();

        alu(4'd3, 5'd5, 32'hDEADBEEF, "alu");
        chk("alu_count", retired_count, exp_count);

        alu(4'd6, 5'd7, 32'h11111111, "b2b0");
        alu(4'd7, 5'd0, 32'h22222222, "b2b1");
        alu(4'd8, 5'd9, 32'h33333333, "b2b2");
        alu(4'd9, 5'd10, 32'h44444444, "b2b3");
        idle();
        chk("b2b_count", retired_count, exp_count);
        tick();

        store_head(32'h100, 32'h55, 3'd2);
        @(negedge clock);
        chk("st_issue_retire", rob_retire, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            mem_st_ack = (i == 2);
            @(negedge clock);
            chk("st_req_hold", mem_st_req, 1);
            chk("st_addr_hold", mem_st_addr, 32'h100);
            chk("st_data_hold", mem_st_data, 32'h55);
            chk("st_size_hold", mem_st_size, 3'd2);
            chk("st_retire", rob_retire, i == 2);
            chk("st_mclr", map_clear_en, 0);
            tick();
        end
        exp_count++;
        idle();
        chk("st_req_drop", mem_st_req, 0);
        chk("st_count", retired_count, exp_count);

        mem_st_ack = 1; head_ready = 1;
        @(negedge clock);
        chk("stray_ack_retire", rob_retire, 0);
        tick();
        chk("stray_ack_count", retired_count, exp_count);
        idle();

        set_head(4'd4, 5'd1, 32'h14);
        head_mispredict = 1; head_target_pc = 32'h200;
        wb_q.push_back({5'd1, 32'h14});
        exp_wb++;
        fl_q.push_back(32'h200);
        @(negedge clock);
        chk("jal_retire", rob_retire, 1);
        chk("jal_mclr_idx", map_clear_idx, 1);
        chk("jal_mclr_tag", map_clear_tag, 4);
        exp_count++;
        tick();
        set_head(4'd5, 5'd2, 32'h7);
        @(negedge clock);
        chk("flush_ignore_retire", rob_retire, 0);
        chk("flush_pulse", flush_out, 1);
        tick();
        alu(4'd5, 5'd2, 32'h7, "post_flush");
        chk("flush_one_cycle", flush_out, 0);
        idle();

        store_head(32'h300, 32'hAA, 3'd0);
        tick();
        reset = 1;
        idle();
        tick();
        chk("rst_st_req", mem_st_req, 0);
        chk("rst_st_count", retired_count, 0);
        exp_count = 0;
        reset = 0;
        alu(4'd1, 5'd4, 32'h1234, "post_rst");
        idle();
        chk("post_rst_count", retired_count, exp_count);

        set_head(4'd6, 5'd3, 32'h99);
        head_halt = 1;
        @(negedge clock);
        chk("wfi_retire", rob_retire, 1);
        chk("wfi_mclr", map_clear_en, 0);
        exp_count++;
        tick();
        chk("wfi_halted", halted, 1);
        chk("wfi_illegal", illegal_out, 0);
        for (int i = 0; i < 3; i++) begin
            set_head(4'd7, 5'd4, 32'h1);
            @(negedge clock);
            chk("halted_no_retire", rob_retire, 0);
            chk("halted_sticky", halted, 1);
            tick();
        end
        chk("halted_count", retired_count, exp_count);

        reset = 1;
        idle();
        tick();
        chk("rst_halt_clear", halted, 0);
        exp_count = 0;
        reset = 0;

        set_head(4'd8, 5'd5, 32'h1);
        head_illegal = 1; head_halt = 1; head_wr_mem = 1; head_mispredict = 1;
        @(negedge clock);
        chk("ill_retire", rob_retire, 1);
        chk("ill_mclr", map_clear_en, 0);
        exp_count++;
        tick();
        idle();
        chk("ill_halted", halted, 1);
        chk("ill_flag", illegal_out, 1);
        chk("ill_no_flush", flush_out, 0);
        chk("ill_no_store", mem_st_req, 0);
        chk("ill_count", retired_count, exp_count);
        tick(); tick();

        chk("wb_q_empty", wb_q.size(), 0);
        chk("st_q_empty", st_q.size(), 0);
        chk("fl_q_empty", fl_q.size(), 0);
        chk("wb_pulses", wb_seen, exp_wb);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/commit_stage.md
Name: commit_stage

Overview:
In-order retirement block at the ROB head. It is the write end of the architectural regfile and maptable interface that the issue stage reads.
- Retires completed head entries one per cycle.
- Produces the regfile write port (wb_reg_wr_en_out, wb_reg_wr_idx_out, wb_reg_wr_data_out).
- Clears matching maptable entries.
- Performs store commit to memory through a req/ack handshake.
- Raises pipeline flush on mispredicted branches and stops on halt or illegal instructions.

Parameters:
XLEN, 32, data/address width.
TAG_W, 4, ROB tag width; tag 0 is reserved as "no producer" and never occupies a ROB entry.
CNT_W, 64, retired-instruction counter width.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
head_valid  in  1  ROB head entry occupied
head_ready  in  1  head result complete
head_tag  in  TAG_W  ROB tag of head
head_dest_reg_idx  in  5  architectural destination (0 = none)
head_value  in  XLEN  result value
head_wr_mem  in  1  head is a store
head_mem_size  in  3  store funct3
head_addr  in  XLEN  store address
head_store_value  in  XLEN  store data
head_mispredict  in  1  branch resolved opposite to prediction
head_target_pc  in  XLEN  correct PC on mispredict
head_halt  in  1  WFI
head_illegal  in  1  illegal instruction
mem_st_ack  in  1  memory accepted/finished store
rob_retire  out  1  pop ROB head at this clock edge
map_clear_en  out  1  clear maptable entry
map_clear_idx  out  5  arch reg to clear
map_clear_tag  out  TAG_W  clear only if maptable tag equals this
wb_reg_wr_en_out  out  1  regfile write enable
wb_reg_wr_idx_out  out  5  regfile write index
wb_reg_wr_data_out  out  XLEN  regfile write data
mem_st_req  out  1  store request
mem_st_addr  out  XLEN  store address
mem_st_data  out  XLEN  store data
mem_st_size  out  3  store size
flush_out  out  1  squash speculative state
flush_pc  out  XLEN  redirect PC
halted  out  1  sticky stop
illegal_out  out  1  sticky illegal-stop flag
retired_count  out  CNT_W  retired instruction count

Behaviour:
- Reset: state RUN. Every output is 0: registered outputs, retired_count, halted, illegal_out, mem_st_*.
- Reset mid-store drops mem_st_req the next cycle with no retire.
- Combinational outputs: rob_retire and map_clear_*.
- Registered outputs (update at the edge of the retire cycle): wb_*, flush_*, mem_st_*, halted, illegal_out, retired_count.
- "ret" means: head_valid & head_ready in state RUN.
- RUN, ret, non-store:
  - rob_retire=1.
  - map_clear_en=1 iff head_dest_reg_idx!=0, with idx/tag taken from the head.
  - Next cycle: wb_reg_wr_en_out=1 iff head_dest_reg_idx!=0, with idx and data from the head. Otherwise wb_reg_wr_en_out=0 (one-cycle pulse).
  - retired_count+1 (wraps modulo 2^CNT_W).
- RUN, ret, mispredict: retire as above (JAL/JALR link still written). Next cycle flush_out=1 for exactly one cycle, flush_pc=head_target_pc. State goes to FLUSH.
- FLUSH: lasts one cycle. Head is ignored and rob_retire=0. Returns to RUN.
- RUN, ret, halt or illegal:
  - rob_retire=1, no regfile write, count+1.
  - halted=1 next cycle; illegal_out=1 if head_illegal.
  - State goes to HALTED.
- HALTED: absorbing. All strobes are 0 until reset.
- RUN, head valid & ready & head_wr_mem:
  - rob_retire=0.
  - Next cycle: mem_st_req=1, with address, data and size latched from the head. State goes to ST_WAIT.
- ST_WAIT:
  - mem_st_req and the latched fields are held stable until mem_st_ack.
  - In the ack cycle: rob_retire=1, count+1, no regfile write, no map clear.
  - Next cycle: mem_st_req=0, state RUN.
  - mem_st_ack outside ST_WAIT is ignored.
- head_valid=0 or head_ready=0 in RUN: no retire, all strobes 0.
- Throughput: 1 retire/cycle for non-stores. Stores take at least 2 cycles (req cycle + ack).
- Priority on head flags: illegal > halt > wr_mem > mispredict > normal.

Test Plan:
- ALU retire: head tag 3, rd 5, value 0xDEADBEEF, ready -> same cycle rob_retire=1 and map_clear (5,3); next cycle wb_en=1, idx 5, data 0xDEADBEEF; retired_count=1.
- Back-to-back: 4 ready heads on consecutive cycles, one with rd=0 -> 4 retire pulses; 3 wb pulses; no map_clear for the rd=0 entry; count=4.
- Store: addr 0x100, data 0x55, size 2, ack after 3 cycles -> mem_st_req high for 3 cycles with stable fields; rob_retire only in the ack cycle; req low the next cycle; no wb.
- Mispredict: JAL rd 1 value 0x14, target 0x200 -> wb x1=0x14 and flush_out pulse with flush_pc 0x200; next head ignored for one cycle.
- Halt/illegal: WFI at head -> retire, halted=1 sticky; later ready heads are not retired. Illegal head -> halted=1 and illegal_out=1.
- Reset during ST_WAIT -> next cycle mem_st_req=0, count=0, state RUN; a fresh ready head retires normally.
